sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_wait_cnt.sv | 27 ++
 rtl/sram_ctrl.sv | 113 +++++++++++
 tb/tb_sram_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the 16-bit external SRAM controller: FSM encoding,
// default data-memory base address and the byte-to-word address mapping.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StWait,
        StDone
    } sram_state_e;

    localparam logic [31:0] DefaultBaseAddr = 32'd1024;

    // Word index within the SRAM; addresses below base wrap modulo 2^17 words.
    function automatic logic [16:0] sram_word(input logic [31:0] addr, input logic [31:0] base);
        return 17'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// 3-bit wait-state counter: cleared on request, terminal count when the
// current cycle is the last of Limit cycles spent counting.
module sram_wait_cnt #(
    parameter int unsigned Limit = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [3:0] LimitW = 4'(Limit);

    logic [2:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_tc = ({1'b0, r_cnt} + 4'd1) == LimitW;

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage to 16-bit SRAM bridge: each 32-bit access is split into a low and
// a high half-word cycle, followed by WAIT_CYCLES idle cycles and a DONE cycle.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N
);

    sram_state_e r_state;
    logic        r_is_wr;
    logic [16:0] r_word;
    logic [15:0] r_wdata_hi;

    logic        w_req;
    logic        w_tc;
    logic        w_cnt_clr;
    logic        w_cnt_en;
    logic [16:0] w_word;

    assign w_req     = wr_en | rd_en;
    assign w_word    = sram_word(address, BASE_ADDR);
    assign w_cnt_clr = (r_state == StHi);
    assign w_cnt_en  = (r_state == StWait);

    assign ready = ~w_req | (r_state == StDone);

    sram_wait_cnt #(
        .Limit(WAIT_CYCLES)
    ) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_clr(w_cnt_clr),
        .i_en (w_cnt_en),
        .o_tc (w_tc)
    );

    // SRAM pins are registered on the edge entering each phase, so they are
    // valid for the whole LO/HI cycle and SRAM_DQ_in is sampled at its end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_is_wr     <= 1'b0;
            r_word      <= '0;
            r_wdata_hi  <= '0;
            readData    <= '0;
            SRAM_ADDR   <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_DQ_out <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_state    <= StLo;
                        r_is_wr    <= wr_en;
                        r_word     <= w_word;
                        r_wdata_hi <= writeData[31:16];
                        SRAM_ADDR  <= {w_word, 1'b0};
                        if (wr_en) begin
                            SRAM_WE_N   <= 1'b0;
                            SRAM_DQ_oe  <= 1'b1;
                            SRAM_DQ_out <= writeData[15:0];
                        end
                    end
                end
                StLo: begin
                    r_state   <= StHi;
                    SRAM_ADDR <= {r_word, 1'b1};
                    if (r_is_wr) begin
                        SRAM_DQ_out <= r_wdata_hi;
                    end else begin
                        readData[15:0] <= SRAM_DQ_in;
                    end
                end
                StHi: begin
                    r_state    <= (WAIT_CYCLES > 0) ? StWait : StDone;
                    SRAM_WE_N  <= 1'b1;
                    SRAM_DQ_oe <= 1'b0;
                    if (!r_is_wr) begin
                        readData[31:16] <= SRAM_DQ_in;
                    end
                end
                StWait: begin
                    if (w_tc) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (default wait states and zero wait
// states) checked every cycle against a cycle-count model of one access.
module tb_sram_ctrl;

    localparam int unsigned W0 = 2;
    localparam int unsigned W1 = 0;
    localparam logic [31:0] Base = 32'd1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en      [2];
    logic        rd_en      [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic        ready      [2];
    logic [17:0] sram_addr  [2];
    logic [15:0] dq_out     [2];
    logic [15:0] dq_in      [2];
    logic        dq_oe      [2];
    logic        we_n       [2];

    function automatic logic [15:0] sram_rd(input logic [17:0] a);
        if (a == 18'd4) return 16'hBEEF;
        if (a == 18'd5) return 16'hDEAD;
        return a[15:0] ^ 16'h5A3C ^ {a[17:16], 14'd0};
    endfunction

    assign dq_in[0] = sram_rd(sram_addr[0]);
    assign dq_in[1] = sram_rd(sram_addr[1]);

    sram_ctrl #(.WAIT_CYCLES(W0), .BASE_ADDR(Base)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .address(address[0]),
        .writeData(write_data[0]), .readData(read_data[0]), .ready(ready[0]),
        .SRAM_ADDR(sram_addr[0]), .SRAM_DQ_out(dq_out[0]), .SRAM_DQ_in(dq_in[0]),
        .SRAM_DQ_oe(dq_oe[0]), .SRAM_WE_N(we_n[0])
    );

    sram_ctrl #(.WAIT_CYCLES(W1), .BASE_ADDR(Base)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .address(address[1]),
        .writeData(write_data[1]), .readData(read_data[1]), .ready(ready[1]),
        .SRAM_ADDR(sram_addr[1]), .SRAM_DQ_out(dq_out[1]), .SRAM_DQ_in(dq_in[1]),
        .SRAM_DQ_oe(dq_oe[1]), .SRAM_WE_N(we_n[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t = cycles into the current access (0 = no access), so the
    // low half is cycle 1, the high half cycle 2 and completion cycle 3+W.
    int          m_t     [2] = '{0, 0};
    logic        m_wr    [2] = '{1'b0, 1'b0};
    logic [16:0] m_word  [2] = '{17'd0, 17'd0};
    logic [15:0] m_wd_hi [2] = '{16'd0, 16'd0};
    logic [15:0] m_dq    [2] = '{16'd0, 16'd0};
    logic [31:0] m_rd    [2] = '{32'd0, 32'd0};
    logic [17:0] m_addr  [2] = '{18'd0, 18'd0};

    always @(negedge clk) begin
        int   w;
        logic req;
        logic drive;
        for (int k = 0; k < 2; k++) begin
            w     = (k == 0) ? int'(W0) : int'(W1);
            req   = wr_en[k] | rd_en[k];
            drive = m_wr[k] && (m_t[k] == 1 || m_t[k] == 2);
            if (chk_en) begin
                check($sformatf("ready%0d", k), {31'd0, ready[k]},
                      {31'd0, !req || (m_t[k] == 3 + w)});
                check($sformatf("we_n%0d", k), {31'd0, we_n[k]}, {31'd0, !drive});
                check($sformatf("oe%0d", k), {31'd0, dq_oe[k]}, {31'd0, drive});
                check($sformatf("addr%0d", k), {14'd0, sram_addr[k]}, {14'd0, m_addr[k]});
                check($sformatf("dq_out%0d", k), {16'd0, dq_out[k]}, {16'd0, m_dq[k]});
                check($sformatf("rdata%0d", k), read_data[k], m_rd[k]);
            end
            if (rst) begin
                m_t[k]    = 0;
                m_rd[k]   = '0;
                m_addr[k] = '0;
                m_dq[k]   = '0;
            end else if (m_t[k] == 0) begin
                if (req) begin
                    m_t[k]     = 1;
                    m_wr[k]    = wr_en[k];
                    m_word[k]  = 17'((address[k] - Base) / 4);
                    m_wd_hi[k] = write_data[k][31:16];
                    m_addr[k]  = {m_word[k], 1'b0};
                    if (wr_en[k]) m_dq[k] = write_data[k][15:0];
                end
            end else begin
                if (m_t[k] == 1) begin
                    m_addr[k] = {m_word[k], 1'b1};
                    if (m_wr[k]) m_dq[k] = m_wd_hi[k];
                    else m_rd[k][15:0] = dq_in[k];
                end
                if (m_t[k] == 2 && !m_wr[k]) m_rd[k][31:16] = dq_in[k];
                m_t[k] = (m_t[k] == 3 + w) ? 0 : m_t[k] + 1;
            end
        end
    end

    // Issue one access on instance k; cycle 0 is the first cycle the request
    // is visible. abort_at >= 0 drops the request after that cycle.
    task automatic do_access(input int k, input logic wr, input logic rd,
                             input logic [31:0] addr, input logic [31:0] data,
                             input bit keep, input int abort_at,
                             output int rdy_cycle, output int we_low,
                             output logic [17:0] a_lo, output logic [17:0] a_hi,
                             output logic [15:0] d_lo, output logic [15:0] d_hi);
        int w;
        w = (k == 0) ? int'(W0) : int'(W1);
        rdy_cycle = -1;
        we_low    = 0;
        a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0;
        @(posedge clk); #2;
        wr_en[k] = wr; rd_en[k] = rd; address[k] = addr; write_data[k] = data;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!we_n[k]) we_low++;
            if (c == 1) begin a_lo = sram_addr[k]; d_lo = dq_out[k]; end
            if (c == 2) begin a_hi = sram_addr[k]; d_hi = dq_out[k]; end
            if (c == abort_at) begin
                @(posedge clk); #2;
                wr_en[k] = 1'b0; rd_en[k] = 1'b0;
                repeat (w + 3) @(posedge clk);
                break;
            end
            if (ready[k]) begin
                rdy_cycle = c;
                break;
            end
            @(posedge clk); #2;
        end
        if (abort_at < 0) begin
            n_checks++;
            if (rdy_cycle < 0) begin
                n_fail++;
                $display("FAIL timeout%0d: ready never rose, required within 40 cycles", k);
            end
        end
        if (!keep) begin
            @(posedge clk); #2;
            wr_en[k] = 1'b0; rd_en[k] = 1'b0;
        end
    endtask

    initial begin
        int          rc, rc2, wl;
        logic [17:0] alo, ahi;
        logic [15:0] dlo, dhi;
        for (int k = 0; k < 2; k++) begin
            wr_en[k] = 1'b0; rd_en[k] = 1'b0; address[k] = Base; write_data[k] = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_rdata", read_data[0], 32'd0);
        check("rst_we_n", {31'd0, we_n[0]}, 32'd1);
        check("rst_ready", {31'd0, ready[0]}, 32'd1);
        check("rst_addr", {14'd0, sram_addr[0]}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Read of two known half-words
        do_access(0, 1'b0, 1'b1, Base + 32'd8, 32'd0, 1'b0, -1, rc, wl, alo, ahi, dlo, dhi);
        check("rd_ready_cycle", rc, 32'd5);
        check("rd_data", read_data[0], 32'hDEADBEEF);
        check("rd_addr_lo", {14'd0, alo}, 32'd4);
        check("rd_addr_hi", {14'd0, ahi}, 32'd5);
        check("rd_we_low", wl, 32'd0);

        // Write splits into low then high half
        do_access(0, 1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, -1, rc, wl, alo, ahi, dlo, dhi);
        check("wr_we_low", wl, 32'd2);
        check("wr_addr_lo", {14'd0, alo}, 32'd2);
        check("wr_dq_lo", {16'd0, dlo}, 32'h5678);
        check("wr_addr_hi", {14'd0, ahi}, 32'd3);
        check("wr_dq_hi", {16'd0, dhi}, 32'h1234);
        check("wr_rdata_held", read_data[0], 32'hDEADBEEF);

        // Write wins over read
        do_access(0, 1'b1, 1'b1, 32'd1040, 32'hAABBCCDD, 1'b0, -1, rc, wl, alo, ahi, dlo, dhi);
        check("both_we_low", wl, 32'd2);
        check("both_rdata", read_data[0], 32'hDEADBEEF);

        // Back-to-back reads with request held
        do_access(0, 1'b0, 1'b1, Base + 32'd8, 32'd0, 1'b1, -1, rc, wl, alo, ahi, dlo, dhi);
        do_access(0, 1'b0, 1'b1, Base + 32'd8, 32'd0, 1'b0, -1, rc2, wl, alo, ahi, dlo, dhi);
        check("b2b_second_ready", rc + 1 + rc2, 32'd11);

        // Reset during the high half of a write
        @(posedge clk); #2;
        wr_en[0] = 1'b1; address[0] = 32'd1100; write_data[0] = 32'hCAFEF00D;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; wr_en[0] = 1'b0;
        @(negedge clk);
        check("rstmid_we_n", {31'd0, we_n[0]}, 32'd1);
        check("rstmid_rdata", read_data[0], 32'd0);
        check("rstmid_oe", {31'd0, dq_oe[0]}, 32'd0);
        repeat (3) @(posedge clk);

        // Zero wait states, address below base
        do_access(1, 1'b0, 1'b1, 32'd1020, 32'd0, 1'b0, -1, rc, wl, alo, ahi, dlo, dhi);
        check("w0_ready_cycle", rc, 32'd3);
        check("w0_addr_lo", {14'd0, alo}, 32'h3FFFE);
        check("w0_addr_hi", {14'd0, ahi}, 32'h3FFFF);

        // Randomized traffic on both instances
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 60; n++) begin
                int          op;
                int          ab;
                bit          kp;
                logic [31:0] a;
                op = int'($urandom_range(0, 2));
                a  = Base + 32'($urandom_range(0, 4096)) - 32'd2048;
                kp = ($urandom_range(0, 3) == 0) && (n != 59);
                ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : -1;
                if (ab >= 0) kp = 1'b0;
                do_access(k, op != 0, op != 1, a, $urandom, kp, ab, rc, wl, alo, ahi, dlo, dhi);
                if (!kp) repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            repeat (4) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required end before 500000");
        $fatal(1);
    end

endmodule
